// File: rtl/sudoku_grid_writer.sv
// Serialises a latched 9x9 one-hot Sudoku grid into ASCII digits (optionally CR LF per row),
// handing one byte at a time to a UART transmitter via a ready/completed handshake.
module sudoku_grid_writer #(
    parameter int p_ROW_TERM = 1,
    parameter int p_GAP_CLKS = 0
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         i_Start,
    input  logic [728:0] i_Grid,
    output logic [7:0]   o_Tx_Byte,
    output logic         o_Tx_Ready,
    input  logic         i_Tx_Completed,
    output logic         o_Busy,
    output logic         o_Done,
    output logic         o_Error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [15:0] GAP_LAST = (p_GAP_CLKS > 0) ? 16'(p_GAP_CLKS - 1) : 16'd0;
    // Column value 9 marks the terminator slot; term selects CR (0) or LF (1).
    localparam logic [3:0]  COL_TERM = 4'd9;

    state_t        state_reg, state_next;
    logic [728:0]  grid_reg, grid_next;
    logic [3:0]    row_reg, row_next;
    logic [3:0]    col_reg, col_next;
    logic          term_reg, term_next;
    logic [15:0]   gap_reg, gap_next;
    logic [7:0]    tx_byte_reg, tx_byte_next;
    logic          error_reg, error_next;

    logic [8:0]    cells [81];
    logic [80:0]   cell_multi;
    logic          any_multi;

    genvar gi;
    generate
        for (gi = 0; gi < 81; gi++) begin : g_cell
            assign cells[gi]      = grid_reg[gi*9 +: 9];
            assign cell_multi[gi] = |(cells[gi] & (cells[gi] - 9'd1));
        end
    endgenerate

    assign any_multi = |cell_multi;

    // Position following the current byte; adv_last flags that the current byte is the final one.
    logic [3:0] adv_row, adv_col;
    logic       adv_term, adv_last;

    always_comb begin
        adv_row  = row_reg;
        adv_col  = col_reg;
        adv_term = term_reg;
        adv_last = 1'b0;
        if (col_reg < 4'd8) begin
            adv_col = col_reg + 4'd1;
        end else if (col_reg == 4'd8 && p_ROW_TERM != 0) begin
            adv_col  = COL_TERM;
            adv_term = 1'b0;
        end else if (col_reg == COL_TERM && !term_reg) begin
            adv_term = 1'b1;
        end else if (row_reg == 4'd8) begin
            adv_last = 1'b1;
        end else begin
            adv_row  = row_reg + 4'd1;
            adv_col  = 4'd0;
            adv_term = 1'b0;
        end
    end

    // Byte for the position about to be sent: advanced position when leaving WAIT, stored otherwise.
    logic [3:0] sel_row, sel_col, sel_col_clamp;
    logic       sel_term;
    logic [6:0] sel_idx;
    logic [8:0] sel_cell;
    logic [7:0] sel_byte;

    always_comb begin
        sel_row       = (state_reg == S_WAIT) ? adv_row  : row_reg;
        sel_col       = (state_reg == S_WAIT) ? adv_col  : col_reg;
        sel_term      = (state_reg == S_WAIT) ? adv_term : term_reg;
        sel_col_clamp = (sel_col > 4'd8) ? 4'd8 : sel_col;
        sel_idx       = 7'(sel_row) * 7'd9 + 7'(sel_col_clamp);
        sel_cell      = cells[sel_idx];
        sel_byte      = 8'h3F;
        if (sel_cell == 9'd0) begin
            sel_byte = 8'h30;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (sel_cell == (9'd1 << k)) sel_byte = 8'h31 + 8'(k);
            end
        end
        if (sel_col == COL_TERM) sel_byte = sel_term ? 8'h0A : 8'h0D;
    end

    always_comb begin
        state_next   = state_reg;
        grid_next    = grid_reg;
        row_next     = row_reg;
        col_next     = col_reg;
        term_next    = term_reg;
        gap_next     = gap_reg;
        tx_byte_next = tx_byte_reg;
        error_next   = error_reg;
        case (state_reg)
            S_IDLE: begin
                if (i_Start) begin
                    grid_next  = i_Grid;
                    error_next = 1'b0;
                    row_next   = 4'd0;
                    col_next   = 4'd0;
                    term_next  = 1'b0;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                error_next   = any_multi;
                tx_byte_next = sel_byte;
                state_next   = S_SEND;
            end
            S_SEND: state_next = S_WAIT;
            S_WAIT: begin
                if (i_Tx_Completed) begin
                    if (adv_last) begin
                        state_next = S_DONE;
                    end else begin
                        row_next  = adv_row;
                        col_next  = adv_col;
                        term_next = adv_term;
                        if (p_GAP_CLKS > 0) begin
                            gap_next   = 16'd0;
                            state_next = S_GAP;
                        end else begin
                            tx_byte_next = sel_byte;
                            state_next   = S_SEND;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    tx_byte_next = sel_byte;
                    state_next   = S_SEND;
                end else begin
                    gap_next = gap_reg + 16'd1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_reg   <= S_IDLE;
            grid_reg    <= '0;
            row_reg     <= 4'd0;
            col_reg     <= 4'd0;
            term_reg    <= 1'b0;
            gap_reg     <= 16'd0;
            tx_byte_reg <= 8'h00;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grid_reg    <= grid_next;
            row_reg     <= row_next;
            col_reg     <= col_next;
            term_reg    <= term_next;
            gap_reg     <= gap_next;
            tx_byte_reg <= tx_byte_next;
            error_reg   <= error_next;
        end
    end

    assign o_Tx_Byte  = tx_byte_reg;
    assign o_Tx_Ready = (state_reg == S_SEND);
    assign o_Busy     = (state_reg == S_LOAD) || (state_reg == S_SEND) ||
                        (state_reg == S_WAIT) || (state_reg == S_GAP);
    assign o_Done     = (state_reg == S_DONE);
    // Error shows during LOAD itself, before the sticky flag is written.
    assign o_Error    = error_reg | ((state_reg == S_LOAD) & any_multi);

endmodule

// File: tb/tb_sudoku_grid_writer.sv
// Self-checking bench for sudoku_grid_writer: vector table of grids, byte scoreboard, timing and reset checks.
module tb_sudoku_grid_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start    [2];
    logic [728:0] grid     [2];
    logic         txc      [2];
    logic [7:0]   tx_byte  [2];
    logic         tx_ready [2];
    logic         busy     [2];
    logic         done     [2];
    logic         err      [2];

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];
    logic [7:0] got [0:127];
    int npulse;

    sudoku_grid_writer #(.p_ROW_TERM(1), .p_GAP_CLKS(0)) dut_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start[0]), .i_Grid(grid[0]),
        .o_Tx_Byte(tx_byte[0]), .o_Tx_Ready(tx_ready[0]), .i_Tx_Completed(txc[0]),
        .o_Busy(busy[0]), .o_Done(done[0]), .o_Error(err[0])
    );

    sudoku_grid_writer #(.p_ROW_TERM(0), .p_GAP_CLKS(5)) dut_b (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start[1]), .i_Grid(grid[1]),
        .o_Tx_Byte(tx_byte[1]), .o_Tx_Ready(tx_ready[1]), .i_Tx_Completed(txc[1]),
        .o_Busy(busy[1]), .o_Done(done[1]), .o_Error(err[1])
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [728:0] make_grid(input int kind, input int br, input int bc,
                                               input logic [8:0] bv);
        string rows [9];
        logic [728:0] g;
        int dg;
        rows = '{"534678912", "672195348", "198342567", "859761423", "426853791",
                 "713924856", "961537284", "287419635", "345286179"};
        g = '0;
        if (kind != 1) begin
            for (int r = 0; r < 9; r++) begin
                for (int c = 0; c < 9; c++) begin
                    dg = int'(rows[r].getc(c)) - 48;
                    g[(r*9+c)*9 +: 9] = 9'd1 << (dg - 1);
                end
            end
        end
        if (kind == 2) g[(br*9+bc)*9 +: 9] = bv;
        return g;
    endfunction

    function automatic logic [7:0] enc(input logic [8:0] v);
        logic [7:0] b;
        b = 8'h3F;
        if ($countones(v) == 0) b = 8'h30;
        else if ($countones(v) == 1)
            for (int k = 0; k < 9; k++) if (v[k]) b = 8'h31 + 8'(k);
        return b;
    endfunction

    task automatic build_expect(input int d, input logic [728:0] g);
        sb.delete();
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) sb.push_back(enc(g[(r*9+c)*9 +: 9]));
            if (d == 0) begin
                sb.push_back(8'h0D);
                sb.push_back(8'h0A);
            end
        end
    endtask

    task automatic run_xfer(input int d, input logic [728:0] g, input int lat,
                            input logic exp_err, input int exp_n, input logic mid);
        int cyc, next_comp, last_comp, exp_pulse, spur, gap_c;
        bit done_seen;
        logic [7:0] exp_b;
        gap_c = (d == 1) ? 5 : 0;
        build_expect(d, g);
        @(negedge clk);
        grid[d] = g;
        start[d] = 1'b1;
        cyc = 0; next_comp = -1; last_comp = -1; exp_pulse = 2; spur = -1;
        npulse = 0; done_seen = 0;
        while (!done_seen && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start[d] = 1'b0;
            txc[d]   = 1'b0;
            if (cyc == 1) begin
                grid[d] = {23{$urandom()}};
                chk("busy_load", busy[d], 1);
                chk("err_load", err[d], exp_err);
            end
            if (mid && cyc == 40) start[d] = 1'b1;
            if (tx_ready[d]) begin
                chk("pulse_time", cyc, exp_pulse);
                if (sb.size() == 0) begin
                    chk("extra_pulse", npulse, exp_n);
                end else begin
                    exp_b = sb.pop_front();
                    chk($sformatf("byte%0d", npulse), tx_byte[d], exp_b);
                end
                if (npulse < 128) got[npulse] = tx_byte[d];
                npulse++;
                next_comp = cyc + lat;
            end
            if (cyc == next_comp) begin
                txc[d] = 1'b1;
                last_comp = cyc;
                exp_pulse = cyc + 1 + gap_c;
                if (gap_c >= 2) spur = cyc + 2;
            end
            if (cyc == spur) txc[d] = 1'b1;
            if (done[d]) begin
                done_seen = 1;
                chk("done_time", cyc, last_comp + 1);
                chk("byte_count", npulse, exp_n);
                chk("err_done", err[d], exp_err);
                chk("busy_done", busy[d], 0);
                chk("sb_empty", sb.size(), 0);
            end
        end
        start[d] = 1'b0;
        txc[d]   = 1'b0;
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL xfer_timeout: got no done after %0d cycles, required done", cyc);
        end
        $display("xfer dut=%0d bytes=%0d err=%0d", d, npulse, err[d]);
    endtask

    typedef struct {
        int         d;
        int         kind;
        int         br;
        int         bc;
        logic [8:0] bv;
        int         lat;
        logic       exp_err;
        int         exp_n;
        logic       mid;
    } vec_t;

    vec_t vecs [6];

    initial begin
        string row0;
        logic [728:0] g;
        int cyc, next_comp, pulses, n30;
        logic [7:0] exp_b;

        vecs[0] = '{0, 0, 0, 0, 9'd0,     10, 1'b0, 99, 1'b0};
        vecs[1] = '{1, 1, 0, 0, 9'd0,      3, 1'b0, 81, 1'b0};
        vecs[2] = '{0, 2, 4, 7, 9'b11,     2, 1'b1, 99, 1'b0};
        vecs[3] = '{0, 0, 0, 0, 9'd0,      1, 1'b0, 99, 1'b1};
        vecs[4] = '{1, 2, 0, 0, 9'h1FF,    4, 1'b1, 81, 1'b0};
        vecs[5] = '{1, 0, 0, 0, 9'd0,      1, 1'b0, 81, 1'b0};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            txc[d]   = 1'b0;
            grid[d]  = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_byte", tx_byte[d], 0);
            chk("rst_ready", tx_ready[d], 0);
            chk("rst_busy", busy[d], 0);
            chk("rst_done", done[d], 0);
            chk("rst_err", err[d], 0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            g = make_grid(vecs[i].kind, vecs[i].br, vecs[i].bc, vecs[i].bv);
            run_xfer(vecs[i].d, g, vecs[i].lat, vecs[i].exp_err, vecs[i].exp_n, vecs[i].mid);
            if (i == 0) begin
                row0 = "534678912";
                for (int k = 0; k < 9; k++) chk("row0_digit", got[k], row0.getc(k));
                chk("row0_cr", got[9], 8'h0D);
                chk("row0_lf", got[10], 8'h0A);
            end
            if (i == 1) begin
                n30 = 0;
                for (int k = 0; k < 81; k++) if (got[k] == 8'h30) n30++;
                chk("zero_grid_digits", n30, 81);
            end
            if (i == 2) chk("bad_cell_51", got[51], 8'h3F);
            if (i == 4) chk("bad_cell_0", got[0], 8'h3F);
        end

        // Abort with an asynchronous reset while the 21st byte is in flight.
        g = make_grid(2, 4, 7, 9'b11);
        build_expect(0, g);
        @(negedge clk);
        grid[0] = g;
        start[0] = 1'b1;
        cyc = 0; next_comp = -1; npulse = 0;
        while (npulse < 21 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start[0] = 1'b0;
            txc[0]   = 1'b0;
            if (tx_ready[0]) begin
                exp_b = sb.pop_front();
                chk("abort_byte", tx_byte[0], exp_b);
                npulse++;
                next_comp = cyc + 3;
            end
            if (cyc == next_comp) txc[0] = 1'b1;
        end
        chk("abort_reached", npulse, 21);
        @(negedge clk);
        chk("pre_rst_busy", busy[0], 1);
        chk("pre_rst_err", err[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_byte", tx_byte[0], 0);
        chk("arst_ready", tx_ready[0], 0);
        chk("arst_busy", busy[0], 0);
        chk("arst_done", done[0], 0);
        chk("arst_err", err[0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            txc[0] = (k % 3 == 0);
            if (tx_ready[0] || done[0]) pulses++;
        end
        txc[0] = 1'b0;
        chk("post_rst_pulses", pulses, 0);
        $display("abort dut=0 bytes_before_reset=%0d pulses_after=%0d", npulse, pulses);

        run_xfer(0, make_grid(0, 0, 0, 9'd0), 2, 1'b0, 99, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1);
    end

endmodule
